// File: rtl/occ_code_packer.sv
// rtl/occ_code_packer.sv - packs 8-bit occupancy codes little-endian into 64-bit words behind a small FIFO
module occ_code_packer #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [7:0]           i_occ_code,
    input  logic                 i_occ_valid,
    output logic                 o_occ_ready,
    input  logic                 i_tree_done,
    output logic [63:0]          o_occupacy_code_64,
    output logic                 o_send_to_ddr,
    input  logic                 i_word_ack,
    output logic                 o_last_word,
    output logic                 o_bfs_finish,
    output logic [CNT_WIDTH-1:0] o_byte_count,
    output logic [CNT_WIDTH-1:0] o_word_count,
    output logic                 o_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_PACK, S_FLUSH, S_DRAIN, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [63:0]   acc;
    logic [2:0]    idx;
    logic          pend_done;
    logic [63:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [OW-1:0] occ;
    logic          fifo_full, fifo_empty, accept, push, pop, start_ok;
    logic [63:0]   push_data;

    assign fifo_full   = (occ == OW'(FIFO_DEPTH));
    assign fifo_empty  = (occ == '0);
    assign start_ok    = i_start && (state == S_IDLE || state == S_DONE);
    // Ready depends only on registered state so a same-cycle pop cannot combinationally open it.
    assign o_occ_ready = (state == S_PACK) && !(idx == 3'd7 && fifo_full);
    assign accept      = i_occ_valid && o_occ_ready;
    assign pop         = i_word_ack && !fifo_empty;

    always_comb begin
        push      = 1'b0;
        push_data = acc;
        if (accept && idx == 3'd7) begin
            push      = 1'b1;
            push_data = {i_occ_code, acc[55:0]};
        end else if (state == S_FLUSH && idx != 3'd0 && !fifo_full) begin
            push      = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (i_start)                          state_nxt = S_PACK;
            S_PACK:         if (i_tree_done)                      state_nxt = S_FLUSH;
            S_FLUSH:        if (idx == 3'd0 || !fifo_full)        state_nxt = S_DRAIN;
            S_DRAIN:        if (fifo_empty)                       state_nxt = S_DONE;
            default:                                              state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            acc          <= '0;
            idx          <= '0;
            pend_done    <= 1'b0;
            o_byte_count <= '0;
            o_word_count <= '0;
        end else if (start_ok) begin
            acc          <= '0;
            idx          <= '0;
            pend_done    <= 1'b0;
            o_byte_count <= '0;
            o_word_count <= '0;
        end else begin
            if (accept) begin
                o_byte_count <= o_byte_count + CNT_WIDTH'(1);
                if (idx == 3'd7) begin
                    acc <= '0;
                    idx <= '0;
                end else begin
                    acc[{idx, 3'b000} +: 8] <= i_occ_code;
                    idx                     <= idx + 3'd1;
                end
            end
            if (state == S_PACK && i_tree_done) pend_done <= 1'b1;
            if (state == S_FLUSH && push) begin
                acc <= '0;
                idx <= '0;
            end
            if (pop) o_word_count <= o_word_count + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage needs no reset: the empty flag masks the head word.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign o_send_to_ddr      = !fifo_empty;
    assign o_occupacy_code_64 = fifo_empty ? 64'd0 : mem[rd_ptr];
    assign o_last_word        = pend_done && (state == S_DRAIN) && (occ == OW'(1));
    assign o_bfs_finish       = (state == S_DONE);
    assign o_busy             = !(state == S_IDLE || state == S_DONE);

endmodule

// File: doc/occ_code_packer.md
Name: occ_code_packer

Overview:
- Sits between the BFS octree core and module_interface.
- Collects the 8-bit occupancy codes the core emits, one per node, and packs them little-endian into 64-bit words.
- Buffers completed words in a small FIFO and presents them as o_occupacy_code_64 / o_send_to_ddr, with a per-word acknowledge from the DDR write side.
- At end of traversal, flushes the partial last word (zero-padded), then reports o_bfs_finish.

Parameters:
- FIFO_DEPTH, 2: number of 64-bit words buffered; power of two, 2..16.
- CNT_WIDTH, 32: width of the byte and word counters.

Ports:
- i_clk  input  1  system clock, all state updates on the rising edge.
- i_rst  input  1  asynchronous active-low reset.
- i_start  input  1  pulse: clear counters and begin a new traversal; honoured only in IDLE or DONE.
- i_occ_code  input  8  occupancy code of one node.
- i_occ_valid  input  1  i_occ_code valid this cycle.
- o_occ_ready  output  1  packer accepts a byte this cycle.
- i_tree_done  input  1  pulse: the core will emit no more codes.
- o_occupacy_code_64  output  64  word at the FIFO head.
- o_send_to_ddr  output  1  FIFO head valid.
- i_word_ack  input  1  pulse: the consumer has taken the head word.
- o_last_word  output  1  head word is the final word of the traversal.
- o_bfs_finish  output  1  all words acknowledged; level, held until i_start.
- o_byte_count  output  CNT_WIDTH  bytes accepted in this traversal.
- o_word_count  output  CNT_WIDTH  words acknowledged in this traversal.
- o_busy  output  1  state is not IDLE and not DONE.

Behaviour:
- Reset (i_rst=0, async): state=IDLE, accumulator=0, byte index=0, FIFO empty, pending-done flag=0, both counters=0.
  - All outputs read 0.
- States: IDLE, PACK, FLUSH, DRAIN, DONE.
- IDLE/DONE --i_start--> PACK.
  - Clears counters, accumulator, index, o_bfs_finish.
  - i_start in any other state is ignored.
- Ready rule: o_occ_ready = (state==PACK) && !(index==7 && fifo_full).
  - A pop in the same cycle does not relax ready.
- Byte accept (valid && ready):
  - acc[index*8 +: 8] <= code.
  - o_byte_count increments by 1.
  - If index==7: push {code, acc[55:0]} into the FIFO, clear acc, index <= 0. Otherwise index <= index+1.
- Byte order: the first byte of a word lands in bits [7:0], the eighth in [63:56].
- i_tree_done in PACK:
  - Sets the pending-done flag.
  - A byte accepted in the same cycle is included.
  - Next cycle: go to FLUSH.
  - i_tree_done outside PACK is ignored.
- FLUSH:
  - If index>0: wait until the FIFO is not full, push acc (unused high bytes = 0), clear acc and index, go to DRAIN.
  - If index==0: go to DRAIN immediately.
  - o_occ_ready=0.
- DRAIN: when the FIFO is empty, go to DONE.
- DONE:
  - o_bfs_finish=1; stays until the next i_start.
  - Counters hold their values.
- FIFO:
  - o_send_to_ddr = !empty; o_occupacy_code_64 = head, 0 when empty.
  - i_word_ack while o_send_to_ddr=1 pops the head and increments o_word_count. i_word_ack while empty is ignored.
  - A push and a pop in the same cycle leave the occupancy unchanged. A push never occurs when full.
  - Latency: the word becomes visible on o_send_to_ddr the cycle after the eighth byte is accepted.
- o_last_word = (state==DRAIN) && occupancy==1.
- Empty traversal (i_tree_done with no bytes): PACK -> FLUSH -> DRAIN -> DONE, no words produced, o_word_count=0.
- Asynchronous reset mid-traversal discards all buffered data immediately.

Test Plan:
- Bytes 0x11,0x22,...,0x88 back-to-back, ack on first o_send_to_ddr:
  - o_occupacy_code_64=0x8877665544332211 one cycle after 0x88.
  - o_byte_count=8, o_word_count=1.
- Bytes 0xAA,0xBB,0xCC then i_tree_done:
  - One word 0x0000000000CCBBAA with o_last_word=1.
  - After ack: o_bfs_finish=1, o_word_count=1.
- Backpressure, FIFO_DEPTH=2, no acks, 24 bytes offered continuously:
  - o_occ_ready drops with index==7 on the third word after 23 accepted.
  - One ack lets the 24th byte in.
  - Three words total, in order.
- i_tree_done in the same cycle as the 8th byte:
  - Full word pushed, FLUSH pushes nothing, exactly 1 word, then DONE.
- i_tree_done with zero bytes:
  - o_send_to_ddr never asserts; o_bfs_finish=1 within 3 cycles; counters 0.
- i_rst low mid-word with one word buffered:
  - Outputs 0 immediately (async).
  - After release plus i_start, the next 8 bytes produce a clean word with no stale bytes.
